fetch_sequencer: RTL and testbench

Program-counter sequencer for the single-cycle CPU. It owns the 10-bit PC register and computes the next PC for sequential, jump, conditional-jump, call, return, interrupt-entry and interrupt-return flow. It drives the push/pop side of the 8-entry return-address stack and consumes the stack's pop output. It tracks stack depth so that overflow and underflow stop the core cleanly instead of corrupting the stack pointer.

---
 rtl/fetch_sequencer_pkg.sv | 16 +
 rtl/fetch_sequencer_next_pc_sel.sv | 40 ++++
 rtl/fetch_sequencer.sv | 154 +++++++++++++++
 tb/tb_fetch_sequencer.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_sequencer_pkg.sv
// Shared constants and state encoding for the fetch sequencer and its return-address stack.
package fetch_sequencer_pkg;

  localparam int PC_W    = 10;
  localparam int DEPTH   = 8;
  localparam int DEPTH_W = $clog2(DEPTH + 1);

  localparam logic [PC_W-1:0] IRQ_VECTOR = 10'h3F0;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HALT  = 2'd1,
    FAULT = 2'd2
  } fsm_state_t;

endpackage

// File: rtl/fetch_sequencer_next_pc_sel.sv
// Next-PC mux: resolves jumps/branches, then lets call/return override the result.
module next_pc_sel
  import fetch_sequencer_pkg::*;
(
  input  logic            jmp,
  input  logic            jz,
  input  logic            jnz,
  input  logic            call,
  input  logic            ret,
  input  logic            reti,
  input  logic            zero,
  input  logic [PC_W-1:0] seq,
  input  logic [PC_W-1:0] target,
  input  logic [PC_W-1:0] pop_data,
  output logic [PC_W-1:0] next_pc,
  output logic [PC_W-1:0] branch_pc
);

  logic take_branch;

  // NOTE: combinational blocks use blocking '=' and assign every output a
  // default first, so the last assignment wins and no latch is inferred.
  always_comb begin
    take_branch = (jz & zero) | (jnz & ~zero);
    branch_pc   = seq;
    if (jz | jnz) begin
      branch_pc = take_branch ? target : seq;
    end else if (jmp) begin
      branch_pc = target;
    end

    next_pc = branch_pc;
    if (ret | reti) begin
      next_pc = pop_data;
    end else if (call) begin
      next_pc = target;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Program-counter sequencer: PC register, return-stack depth tracking, interrupt
// entry/return and the RUN/HALT/FAULT state machine.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               jmp,
  input  logic               jz,
  input  logic               jnz,
  input  logic               call,
  input  logic               ret,
  input  logic               reti,
  input  logic               halt,
  input  logic [PC_W-1:0]    target,
  input  logic               zero,
  input  logic               irq,
  input  logic [PC_W-1:0]    pop_data,
  output logic [PC_W-1:0]    pc,
  output logic               push,
  output logic [PC_W-1:0]    push_data,
  output logic               pop,
  output logic               irq_ack,
  output logic [DEPTH_W-1:0] depth,
  output logic               halted,
  output logic               fault
);

  fsm_state_t         state, state_d;
  logic               ie, ie_d;
  logic [PC_W-1:0]    pc_d, seq, next_pc, branch_pc, push_data_c;
  logic [DEPTH_W-1:0] depth_d;
  logic               push_c, pop_c, ack_c;
  logic               stack_full, stack_empty, irq_take;

  assign seq         = pc + PC_W'(1);
  assign stack_full  = (depth == DEPTH_W'(DEPTH));
  assign stack_empty = (depth == '0);
  assign irq_take    = irq & ie;

  next_pc_sel u_next_pc_sel (
    .jmp       (jmp),
    .jz        (jz),
    .jnz       (jnz),
    .call      (call),
    .ret       (ret),
    .reti      (reti),
    .zero      (zero),
    .seq       (seq),
    .target    (target),
    .pop_data  (pop_data),
    .next_pc   (next_pc),
    .branch_pc (branch_pc)
  );

  always_comb begin
    state_d     = state;
    pc_d        = pc;
    ie_d        = ie;
    depth_d     = depth;
    push_c      = 1'b0;
    pop_c       = 1'b0;
    ack_c       = 1'b0;
    push_data_c = seq;

    unique case (state)
      RUN: begin
        if (halt) begin
          state_d = HALT;
        end else if (ret | reti) begin
          if (stack_empty) begin
            state_d = FAULT;
          end else begin
            pop_c   = 1'b1;
            pc_d    = next_pc;
            depth_d = depth - DEPTH_W'(1);
            if (!ret) ie_d = 1'b1;
          end
        end else if (call) begin
          if (stack_full) begin
            state_d = FAULT;
          end else begin
            push_c  = 1'b1;
            pc_d    = next_pc;
            depth_d = depth + DEPTH_W'(1);
            if (target == IRQ_VECTOR) ie_d = 1'b1;
          end
        end else if (irq_take) begin
          if (stack_full) begin
            state_d = FAULT;
          end else begin
            // The interrupted instruction still completes: its resolved
            // destination is what reti must come back to.
            push_c      = 1'b1;
            push_data_c = branch_pc;
            ack_c       = 1'b1;
            pc_d        = IRQ_VECTOR;
            ie_d        = 1'b0;
            depth_d     = depth + DEPTH_W'(1);
          end
        end else begin
          pc_d = next_pc;
        end
      end

      HALT: begin
        if (irq_take) begin
          if (stack_full) begin
            state_d = FAULT;
          end else begin
            push_c  = 1'b1;
            ack_c   = 1'b1;
            pc_d    = IRQ_VECTOR;
            ie_d    = 1'b0;
            depth_d = depth + DEPTH_W'(1);
            state_d = RUN;
          end
        end
      end

      default: begin
        state_d = FAULT;
      end
    endcase
  end

  // Strobes are qualified by reset so an asserted reset kills a push/pop in
  // the same cycle instead of waiting for the registered state to clear.
  assign push      = push_c & reset;
  assign pop       = pop_c & reset;
  assign irq_ack   = ack_c & reset;
  assign push_data = push_data_c;

  // NOTE: sequential state uses non-blocking '<=' so every register samples
  // the pre-edge values of the others.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= RUN;
      pc     <= '0;
      ie     <= 1'b0;
      depth  <= '0;
      halted <= 1'b0;
      fault  <= 1'b0;
    end else begin
      state  <= state_d;
      pc     <= pc_d;
      ie     <= ie_d;
      depth  <= depth_d;
      halted <= (state_d == HALT);
      fault  <= (state_d == FAULT);
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench: a behavioural model with a queue-based return stack predicts every output.
module tb_fetch_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       jmp, jz, jnz, call, ret, reti, halt, zero, irq;
  logic [9:0] target, pop_data;
  logic [9:0] pc, push_data;
  logic       push, pop, irq_ack, halted, fault;
  logic [3:0] depth;

  int checks = 0;
  int errors = 0;

  fetch_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .jmp       (jmp),
    .jz        (jz),
    .jnz       (jnz),
    .call      (call),
    .ret       (ret),
    .reti      (reti),
    .halt      (halt),
    .target    (target),
    .zero      (zero),
    .irq       (irq),
    .pop_data  (pop_data),
    .pc        (pc),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .irq_ack   (irq_ack),
    .depth     (depth),
    .halted    (halted),
    .fault     (fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_pc     = 0;
  bit m_ie     = 0;
  bit m_halted = 0;
  bit m_fault  = 0;
  int rs[$];
  bit cmp_en   = 0;

  typedef struct {
    bit push;
    int push_data;
    bit pop;
    bit ack;
    int next_pc;
    bit ie;
    bit halted;
    bit fault;
  } pred_t;

  function automatic pred_t predict();
    pred_t p;
    int    seq, flow;
    p.push = 0; p.pop = 0; p.ack = 0; p.push_data = 0;
    p.next_pc = m_pc; p.ie = m_ie; p.halted = m_halted; p.fault = m_fault;
    if (reset !== 1'b1 || m_fault) return p;
    seq = (m_pc + 1) % 1024;
    if (m_halted) begin
      if (irq && m_ie) begin
        if (rs.size() == 8) begin
          p.fault = 1; p.halted = 0;
        end else begin
          p.push = 1; p.push_data = seq; p.ack = 1;
          p.next_pc = 'h3F0; p.ie = 0; p.halted = 0;
        end
      end
      return p;
    end
    if ((jz && zero) || (jnz && !zero)) flow = target;
    else if (jz || jnz)                 flow = seq;
    else if (jmp)                       flow = target;
    else                                flow = seq;

    if (halt) begin
      p.halted = 1;
    end else if (ret || reti) begin
      if (rs.size() == 0) p.fault = 1;
      else begin
        p.pop = 1; p.next_pc = rs[$];
        if (!ret) p.ie = 1;
      end
    end else if (call) begin
      if (rs.size() == 8) p.fault = 1;
      else begin
        p.push = 1; p.push_data = seq; p.next_pc = target;
        if (target == 10'h3F0) p.ie = 1;
      end
    end else if (irq && m_ie) begin
      if (rs.size() == 8) p.fault = 1;
      else begin
        p.push = 1; p.push_data = flow; p.ack = 1;
        p.next_pc = 'h3F0; p.ie = 0;
      end
    end else begin
      p.next_pc = flow;
    end
    return p;
  endfunction

  always @(posedge clk or negedge reset) begin
    pred_t p;
    if (!reset) begin
      m_pc = 0; m_ie = 0; m_halted = 0; m_fault = 0;
      rs.delete();
    end else begin
      p = predict();
      if (p.push) rs.push_back(p.push_data);
      if (p.pop)  void'(rs.pop_back());
      m_pc = p.next_pc; m_ie = p.ie; m_halted = p.halted; m_fault = p.fault;
    end
  end

  // Single compare process: every cycle, mid-period, against the model.
  always @(negedge clk) begin
    pred_t p;
    if (cmp_en) begin
      p = predict();
      check("pc", pc, m_pc);
      check("depth", depth, rs.size());
      check("halted", halted, m_halted);
      check("fault", fault, m_fault);
      check("push", push, p.push);
      check("pop", pop, p.pop);
      check("irq_ack", irq_ack, p.ack);
      if (p.push) check("push_data", push_data, p.push_data);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic clear_inputs();
    {jmp, jz, jnz, call, ret, reti, halt, zero, irq} = '0;
    target = '0;
  endtask

  task automatic fix_pop();
    pop_data = (rs.size() > 0) ? 10'(rs[$]) : 10'($urandom);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    clear_inputs();
    fix_pop();
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic random_inputs();
    int r;
    r = $urandom_range(0, 99);
    if      (r < 3)  halt = 1;
    else if (r < 15) ret  = 1;
    else if (r < 19) reti = 1;
    else if (r < 34) call = 1;
    else if (r < 44) jz   = 1;
    else if (r < 54) jnz  = 1;
    else if (r < 64) jmp  = 1;
    if ($urandom_range(0, 9) == 0) begin
      jmp  = jmp  | 1'($urandom_range(0, 1));
      jz   = jz   | 1'($urandom_range(0, 1));
      jnz  = jnz  | 1'($urandom_range(0, 1));
      call = call | 1'($urandom_range(0, 1));
      reti = reti | 1'($urandom_range(0, 1));
    end
    zero   = 1'($urandom_range(0, 1));
    irq    = ($urandom_range(0, 9) < 3);
    target = ($urandom_range(0, 4) == 0) ? 10'h3F0 : 10'($urandom);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    clear_inputs();
    pop_data = '0;
    #2 reset = 1'b0;
    cmp_en = 1;
    tick();
    tick();
    reset = 1'b1;
    settle();
    check("reset_pc", pc, 10'h000);
    check("reset_depth", depth, 4'd0);
    check("reset_halted", halted, 1'b0);
    check("reset_fault", fault, 1'b0);
    check("reset_push", push, 1'b0);

    for (int k = 1; k <= 3; k++) begin
      tick(); settle();
      check("idle_pc", pc, 32'(k));
    end

    // Wrap-around from the top of the address space.
    jmp = 1; target = 10'h3FF; tick(); settle();
    check("jmp_3ff", pc, 10'h3FF);
    tick(); settle();
    check("wrap_pc", pc, 10'h000);

    jz = 1; zero = 1; target = 10'h040; tick(); settle();
    check("jz_taken", pc, 10'h040);
    jz = 1; zero = 0; target = 10'h100; tick(); settle();
    check("jz_not_taken", pc, 10'h041);
    jnz = 1; zero = 0; target = 10'h080; tick(); settle();
    check("jnz_taken", pc, 10'h080);
    jnz = 1; zero = 1; target = 10'h200; tick(); settle();
    check("jnz_not_taken", pc, 10'h081);

    // Call / return round trip.
    jmp = 1; target = 10'h020; tick();
    call = 1; target = 10'h100; settle();
    check("call_push", push, 1'b1);
    check("call_push_data", push_data, 10'h021);
    tick(); settle();
    check("call_pc", pc, 10'h100);
    check("call_depth", depth, 4'd1);
    ret = 1; settle();
    check("ret_pop", pop, 1'b1);
    check("ret_pop_data", pop_data, 10'h021);
    tick(); settle();
    check("ret_pc", pc, 10'h021);
    check("ret_depth", depth, 4'd0);

    // Overflow on the ninth nested call.
    for (int i = 0; i < 8; i++) begin
      call = 1; target = 10'(10'h100 + i * 8); tick();
    end
    settle();
    check("nest_depth", depth, 4'd8);
    call = 1; target = 10'h2AA; settle();
    check("ovf_no_push", push, 1'b0);
    tick(); settle();
    check("ovf_pc_held", pc, 10'h138);
    check("ovf_fault", fault, 1'b1);
    tick(); settle();
    check("fault_frozen", pc, 10'h138);

    // Underflow right after reset.
    do_reset();
    ret = 1; settle();
    check("unf_no_pop", pop, 1'b0);
    tick(); settle();
    check("unf_fault", fault, 1'b1);
    check("unf_pc", pc, 10'h000);

    // Interrupt during a jump, then reti.
    do_reset();
    call = 1; target = 10'h3F0; tick();
    jmp = 1; target = 10'h050; tick();
    jmp = 1; target = 10'h070; irq = 1; settle();
    check("irq_push", push, 1'b1);
    check("irq_push_data", push_data, 10'h070);
    check("irq_ack", irq_ack, 1'b1);
    tick();
    irq = 1; settle();
    check("irq_pc", pc, 10'h3F0);
    check("irq_depth", depth, 4'd2);
    check("irq_ack_one_cycle", irq_ack, 1'b0);
    tick();
    reti = 1; settle();
    check("reti_pop", pop, 1'b1);
    tick(); settle();
    check("reti_pc", pc, 10'h070);
    irq = 1; settle();
    check("reti_sets_ie", irq_ack, 1'b1);
    check("reti_irq_push_data", push_data, 10'h071);
    tick();

    // HALT, hold, wake on interrupt, then reset from HALT.
    do_reset();
    call = 1; target = 10'h3F0; tick();
    jmp = 1; target = 10'h030; tick();
    halt = 1; tick(); settle();
    check("halt_halted", halted, 1'b1);
    check("halt_pc", pc, 10'h030);
    for (int k = 0; k < 5; k++) begin
      jmp = 1; target = 10'($urandom); tick(); settle();
      check("halt_hold_pc", pc, 10'h030);
    end
    irq = 1; settle();
    check("halt_irq_push", push, 1'b1);
    check("halt_irq_push_data", push_data, 10'h031);
    check("halt_irq_ack", irq_ack, 1'b1);
    tick(); settle();
    check("halt_wake_pc", pc, 10'h3F0);
    check("halt_wake_halted", halted, 1'b0);
    check("halt_wake_depth", depth, 4'd2);
    halt = 1; tick(); settle();
    check("halt_again", halted, 1'b1);
    reset = 1'b0; settle();
    check("rst_halt_pc", pc, 10'h000);
    check("rst_halt_halted", halted, 1'b0);
    check("rst_halt_depth", depth, 4'd0);
    tick();
    reset = 1'b1;
    tick();
    call = 1; target = 10'h100; settle();
    check("pre_rst_push", push, 1'b1);
    reset = 1'b0; settle();
    check("rst_call_push", push, 1'b0);
    tick();
    reset = 1'b1;

    // Randomised traffic with periodic resets to leave terminal states.
    for (int n = 0; n < 900; n++) begin
      if (n % 60 == 59) begin
        do_reset();
      end else begin
        random_inputs();
        tick();
      end
    end

    cmp_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
